// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the load/store controller: access-size codes,
// FSM states and the fixed data width.
package mem_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] low);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return low[0];
      SZ_WORD: return (low != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus word-addressed data memory port of the
// load/store controller; slave = controller view, master = CPU/memory view.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wrData;
  logic        mem_wrMem;
  logic        mem_rdMem;
  logic [31:0] mem_rdData;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_rdData,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_addr, mem_wrData, mem_wrMem, mem_rdMem
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_rdData,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_addr, mem_wrData, mem_wrMem, mem_rdMem
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends a sub-word load from a
// memory line, and merges store data into the addressed lane of that line.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] line,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        lane,
  input  size_e             size,
  input  logic              sgn,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [4:0]  byte_sh_s;
  logic [4:0]  half_sh_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and per-size extend/merge
  always_comb begin
    byte_sh_s = {lane, 3'b000};
    half_sh_s = {lane[1], 4'b0000};
    byte_s    = 8'(line >> byte_sh_s);
    half_s    = 16'(line >> half_sh_s);
    load_data = '0;
    merged    = line;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sgn & byte_s[7]}}, byte_s};
        merged    = (line & ~(32'h0000_00FF << byte_sh_s)) | ({24'h0, wdata[7:0]} << byte_sh_s);
      end
      SZ_HALF: begin
        load_data = {{16{sgn & half_s[15]}}, half_s};
        merged    = (line & ~(32'h0000_FFFF << half_sh_s)) | ({16'h0, wdata[15:0]} << half_sh_s);
      end
      SZ_WORD: begin
        load_data = line;
        merged    = wdata;
      end
      default: begin
        load_data = '0;
        merged    = line;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side load/store controller in front of a word-addressed data memory.
// Optional MEM_ACC_STATS_EN adds saturating load/store/error counters.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_ctrl_if.slave bus
`ifdef MEM_ACC_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  localparam logic [32:0] ADDR_LIM_C = 33'(64'd1 << (MEM_AW + 2));

  state_e            state_r, state_nxt_s;
  logic              ready_r, rd_r, wr_r, resp_valid_r;
  logic              ready_nxt_s, rd_nxt_s, wr_nxt_s, resp_valid_nxt_s;
  logic              we_r, signed_r;
  size_e             size_r, req_size_s;
  logic [1:0]        lane_r;
  logic [DATA_W-1:0] wdata_r, resp_data_r, mem_addr_r, mem_wrdata_r;
  logic              resp_err_r;
  logic              accept_s, resp_hs_s, req_err_s;
  logic [DATA_W-1:0] load_data_s, merged_s;

  assign req_size_s = size_e'(bus.req_size);
  assign accept_s   = bus.req_valid & ready_r;
  assign resp_hs_s  = resp_valid_r & bus.resp_ready;
  assign req_err_s  = is_misaligned(req_size_s, bus.req_addr[1:0]) |
                      ({1'b0, bus.req_addr} >= ADDR_LIM_C);

  mem_lane_align u_align (
    .line      (bus.mem_rdData),
    .wdata     (wdata_r),
    .lane      (lane_r),
    .size      (size_r),
    .sgn       (signed_r),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // State register with registered Moore decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ready_r      <= 1'b1;
      rd_r         <= 1'b0;
      wr_r         <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      ready_r      <= ready_nxt_s;
      rd_r         <= rd_nxt_s;
      wr_r         <= wr_nxt_s;
      resp_valid_r <= resp_valid_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (req_err_s) begin
          state_nxt_s = RESP;
        end else if (bus.req_we && (req_size_s == SZ_WORD)) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = READ;
        end
      end
      READ:    state_nxt_s = we_r ? WRITE : RESP;
      WRITE:   state_nxt_s = RESP;
      RESP:    state_nxt_s = bus.resp_ready ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered above so strobes are glitch-free
  always_comb begin
    ready_nxt_s      = 1'b0;
    rd_nxt_s         = 1'b0;
    wr_nxt_s         = 1'b0;
    resp_valid_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE:    ready_nxt_s      = 1'b1;
      READ:    rd_nxt_s         = 1'b1;
      WRITE:   wr_nxt_s         = 1'b1;
      RESP:    resp_valid_nxt_s = 1'b1;
      default: ready_nxt_s      = 1'b1;
    endcase
  end

  // Request capture, read-cycle results and memory address/data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r         <= 1'b0;
      signed_r     <= 1'b0;
      size_r       <= SZ_BYTE;
      lane_r       <= 2'b00;
      wdata_r      <= '0;
      mem_addr_r   <= '0;
      mem_wrdata_r <= '0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
    end else if (accept_s) begin
      we_r         <= bus.req_we;
      signed_r     <= bus.req_signed;
      size_r       <= req_size_s;
      lane_r       <= bus.req_addr[1:0];
      wdata_r      <= bus.req_wdata;
      mem_addr_r   <= {2'b00, bus.req_addr[31:2]};
      mem_wrdata_r <= bus.req_wdata;
      resp_data_r  <= '0;
      resp_err_r   <= req_err_s;
    end else if (state_r == READ) begin
      // rdData is the line buffer: loads keep the extended lane, stores the merged word
      resp_data_r  <= we_r ? '0 : load_data_s;
      mem_wrdata_r <= we_r ? merged_s : mem_wrdata_r;
    end else if (resp_hs_s) begin
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
    end
  end

  assign bus.req_ready  = ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wrData = mem_wrdata_r;
  assign bus.mem_wrMem  = wr_r;
  assign bus.mem_rdMem  = rd_r;

`ifdef MEM_ACC_STATS_EN
  logic [15:0] loads_r, stores_r, errs_r;

  // Per-class response counters; errors never count as loads or stores
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_r  <= 16'h0000;
      stores_r <= 16'h0000;
      errs_r   <= 16'h0000;
    end else if (resp_hs_s) begin
      if (resp_err_r) begin
        errs_r <= sat_inc16(errs_r);
      end else if (we_r) begin
        stores_r <= sat_inc16(stores_r);
      end else begin
        loads_r <= sat_inc16(loads_r);
      end
    end
  end

  assign stat_loads  = loads_r;
  assign stat_stores = stores_r;
  assign stat_errs   = errs_r;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a behavioural data memory.
// Build with MEM_ACC_STATS_EN defined to also check the statistics counters.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mem_access_ctrl_if bus ();

`ifdef MEM_ACC_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  mem_access_ctrl #(.MEM_AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ACC_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  int wr_seen = 0;

  assign bus.mem_rdData = mem[bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (bus.mem_wrMem) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wrData;
      wr_seen <= wr_seen + 1;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  int t_rd, t_wr, t_resp, n_rd, n_wr;
  logic [31:0] w_data, m_addr, r_data;
  logic r_err;

  // One transaction with resp_ready high; starts and ends 1 time unit after an edge in IDLE.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd);
    t_rd = 0; t_wr = 0; t_resp = 0; n_rd = 0; n_wr = 0;
    w_data = 32'h0; m_addr = 32'h0; r_data = 32'h0; r_err = 1'b0;
    bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int i = 1; i <= 8 && t_resp == 0; i++) begin
      if (bus.mem_rdMem) begin
        n_rd++;
        if (t_rd == 0) t_rd = i;
        m_addr = bus.mem_addr;
      end
      if (bus.mem_wrMem) begin
        n_wr++;
        if (t_wr == 0) t_wr = i;
        w_data = bus.mem_wrData;
        m_addr = bus.mem_addr;
      end
      if (bus.resp_valid) begin
        t_resp = i;
        r_data = bus.resp_data;
        r_err  = bus.resp_err;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  logic [1:0]  e_sz [4];
  logic [31:0] e_ad [4];
  int wr_before;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req_ready",  {31'h0, bus.req_ready}, 32'h1);
    check_val("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check_val("rst_resp_data",  bus.resp_data, 32'h0);
    check_val("rst_strobes",    {30'h0, bus.mem_rdMem, bus.mem_wrMem}, 32'h0);
    check_val("rst_mem_addr",   bus.mem_addr, 32'h0);
    check_val("rst_mem_wrdata", bus.mem_wrData, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then word load at 0x20
    xact(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
    check_val("wst_t_wr",   t_wr, 32'd1);
    check_val("wst_n_wr",   n_wr, 32'd1);
    check_val("wst_n_rd",   n_rd, 32'd0);
    check_val("wst_t_resp", t_resp, 32'd2);
    check_val("wst_addr",   m_addr, 32'd8);
    check_val("wst_wdata",  w_data, 32'hDEADBEEF);
    check_val("wst_resp",   {r_data[30:0], r_err}, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check_val("wld_t_rd",   t_rd, 32'd1);
    check_val("wld_n_wr",   n_wr, 32'd0);
    check_val("wld_t_resp", t_resp, 32'd2);
    check_val("wld_data",   r_data, 32'hDEADBEEF);
    check_val("wld_err",    {31'h0, r_err}, 32'h0);

    // Sub-word loads from word 4 = 0x8899AABB
    xact(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
    xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    check_val("lb_s_11",  r_data, 32'hFFFFFFAA);
    xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check_val("lb_u_11",  r_data, 32'h000000AA);
    xact(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check_val("lh_s_12",  r_data, 32'hFFFF8899);
    xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check_val("lh_u_10",  r_data, 32'h0000AABB);
    xact(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    check_val("lb_s_10",  r_data, 32'hFFFFFFBB);
    xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check_val("lb_u_13",  r_data, 32'h00000088);

    // Sub-word stores as read-modify-write
    xact(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234);
    check_val("sh_t_rd",   t_rd, 32'd1);
    check_val("sh_t_wr",   t_wr, 32'd2);
    check_val("sh_t_resp", t_resp, 32'd3);
    check_val("sh_wdata",  w_data, 32'h1234AABB);
    check_val("sh_addr",   m_addr, 32'd4);
    xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A);
    check_val("sb_wdata",  w_data, 32'h5A34AABB);
    check_val("sb_n_wr",   n_wr, 32'd1);
    xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_val("rmw_readback", r_data, 32'h5A34AABB);

    // Error requests: response at T1, no strobes
    e_sz[0] = 2'b10; e_ad[0] = 32'h22;
    e_sz[1] = 2'b01; e_ad[1] = 32'h11;
    e_sz[2] = 2'b11; e_ad[2] = 32'h20;
    e_sz[3] = 2'b10; e_ad[3] = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      xact(1'b0, e_sz[k], 1'b0, e_ad[k], 32'h0);
      check_val($sformatf("err%0d_t_resp", k), t_resp, 32'd1);
      check_val($sformatf("err%0d_flag", k), {31'h0, r_err}, 32'h1);
      check_val($sformatf("err%0d_data", k), r_data, 32'h0);
      check_val($sformatf("err%0d_strobes", k), n_rd + n_wr, 32'd0);
    end
    xact(1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0);
    check_val("last_byte_err", {31'h0, r_err}, 32'h0);
    check_val("last_byte_rd",  n_rd, 32'd1);

    // Response back-pressure with a second request waiting
    bus.resp_ready = 1'b0;
    bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h20; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_addr = 32'h10;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("bp%0d_valid", i), {31'h0, bus.resp_valid}, 32'h1);
      check_val($sformatf("bp%0d_data", i),  bus.resp_data, 32'hDEADBEEF);
      check_val($sformatf("bp%0d_err", i),   {31'h0, bus.resp_err}, 32'h0);
      check_val($sformatf("bp%0d_ready", i), {31'h0, bus.req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_hs_valid", {31'h0, bus.resp_valid}, 32'h0);
    check_val("bp_hs_rd",    {31'h0, bus.mem_rdMem}, 32'h0);
    check_val("bp_hs_ready", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_val("bp_next_rd",   {31'h0, bus.mem_rdMem}, 32'h1);
    check_val("bp_next_addr", bus.mem_addr, 32'd4);
    @(posedge clk); #1;
    check_val("bp_next_data", bus.resp_data, 32'h5A34AABB);
    @(posedge clk); #1;

    // Reset during the READ of a byte store
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h7E; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_val("abort_in_read", {31'h0, bus.mem_rdMem}, 32'h1);
    wr_before = wr_seen;
    rst_n = 1'b0;
    #1;
    check_val("abort_strobes", {30'h0, bus.mem_rdMem, bus.mem_wrMem}, 32'h0);
    check_val("abort_ready",   {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("abort_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check_val("abort_resp",       {bus.resp_data[30:0], bus.resp_err}, 32'h0);
    check_val("abort_mem_addr",   bus.mem_addr, 32'h0);
    check_val("abort_mem_wrdata", bus.mem_wrData, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_no_write", wr_seen, wr_before);
    check_val("abort_no_resp",  {31'h0, bus.resp_valid}, 32'h0);
    xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    check_val("abort_word_kept", r_data, 32'hDEADBEEF);

    // 3 loads, 2 stores, 1 error since the reset
    xact(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000007E);
    check_val("sb21_wdata", w_data, 32'hDEAD7EEF);
    xact(1'b1, 2'b10, 1'b0, 32'h24, 32'h0);
    xact(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    check_val("lb21", r_data, 32'h0000007E);
    xact(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    check_val("lw24", r_data, 32'h0);
    xact(1'b1, 2'b01, 1'b0, 32'h23, 32'h1);
    check_val("sh23_err",     {31'h0, r_err}, 32'h1);
    check_val("sh23_strobes", n_rd + n_wr, 32'd0);
`ifdef MEM_ACC_STATS_EN
    check_val("stat_loads",  {16'h0, stat_loads}, 32'd3);
    check_val("stat_stores", {16'h0, stat_stores}, 32'd2);
    check_val("stat_errs",   {16'h0, stat_errs}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side load/store controller that drives the word-addressed data memory port (addr, wrData, wrMem, rdMem, rdData) on behalf of the CPU datapath.
- Accepts byte-addressed requests for byte, half and word accesses over a valid/ready handshake.
- Handles sub-word loads with sign or zero extension.
- Performs sub-word stores as read-modify-write.
- Returns a response over a valid/ready handshake.
- Sits between the execute stage and data_mem.

Parameters:
MEM_AW, 10, word-address width of the memory; legal byte addresses are 0 .. 2^(MEM_AW+2)-1.
DATA_W, 32, data width; fixed at 32. Other values are unsupported.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend a sub-word load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_data  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned, illegal-size or out-of-range access
mem_addr  out  32  word index to data_mem (req_addr>>2)
mem_wrData  out  32  write data to data_mem
mem_wrMem  out  1  write strobe
mem_rdMem  out  1  read strobe
mem_rdData  in  32  read data from data_mem; combinational, valid in the same cycle rdMem is high

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, port rst_n.
- Reset values:
  - state IDLE
  - req_ready 1
  - resp_valid 0, resp_data 0, resp_err 0
  - mem_wrMem 0, mem_rdMem 0
  - mem_addr 0, mem_wrData 0
- Registers: mem_wrMem and mem_rdMem are Moore outputs decoded from the state register and must not glitch. mem_addr and mem_wrData come from registers latched at accept.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - Handshake on req_valid&&req_ready latches addr, size, we, signed and wdata.
  - Error check: misaligned (half with addr[0]=1; word with addr[1:0]!=0), size=11, or addr >= 2^(MEM_AW+2) → RESP with err=1. No memory strobe is ever asserted for an errored request.
  - Word store → WRITE.
  - Load or sub-word store → READ.
- READ:
  - mem_rdMem=1 for exactly one cycle.
  - mem_rdData is captured into the line buffer at the cycle's rising edge.
  - Next state: load → RESP; store → WRITE.
- WRITE:
  - mem_wrMem=1 for exactly one cycle.
  - mem_wrData is req_wdata for a word store, or the line buffer with the addressed lane replaced for a sub-word store.
  - Next state: RESP.
- RESP:
  - resp_valid=1 and req_ready=0.
  - resp_data and resp_err are held stable until resp_ready=1; then → IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Lane rules (little-endian):
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - Load result is extended to 32 bits by req_signed (sign) or zeros.
- Latency, with the accept edge as T0 (resp_valid first high):
  - error: T1
  - word store or any load: T2
  - sub-word store: T3
- Mid-operation reset: strobes drop immediately and no write is issued afterward; the aborted request produces no response.
- req_valid while req_ready=0 is ignored; the requester holds it.

Optional Feature:
MEM_ACC_STATS_EN
- Defined:
  - Adds outputs stat_loads, stat_stores and stat_errs, each 16 bits.
  - Each counter is a saturating counter, incremented on the response handshake of its class; an errored request counts only in stat_errs.
  - All counters reset to 0 and saturate at 0xFFFF.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem_ctrl_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum IDLE, READ, WRITE, RESP
  - constant DATA_W=32
- One sub-module, mem_lane_align: purely combinational.
  - Extract and extend for loads.
  - Merge the lane into the line for stores.
  - Shared by the READ→RESP and READ→WRITE paths.

Test Plan:
1. Word store 0xDEADBEEF at 0x20, then word load at 0x20 → mem_addr=8; wrMem high exactly one cycle at T1; resp_valid at T2; load returns 0xDEADBEEF with err=0.
2. Memory word 4 = 0x8899AABB; byte load from 0x11 → 0xFFFFFFAA with signed=1 and 0x000000AA with signed=0; signed half load from 0x12 → 0xFFFF8899.
3. Half store 0x1234 at 0x12 over word 0x8899AABB → rdMem at T1, wrMem at T2 with wrData 0x1234AABB, resp_valid at T3; a byte store 0x5A at 0x13 afterwards → 0x5A34AABB.
4. Error requests → resp_err=1 at T1, resp_data=0, and rdMem/wrMem never asserted, for each of:
   - word load at 0x22
   - half load at 0x11
   - size=11
   - address 0x1000 with MEM_AW=10
5. resp_ready held low 5 cycles → resp_valid, resp_data and resp_err stable and req_ready=0 throughout; a concurrent req_valid is not accepted until the cycle after the handshake.
6. rst_n pulsed low during READ of a byte store → wrMem never asserts, the target word is unchanged, and all outputs return to reset values. With MEM_ACC_STATS_EN defined, after 3 loads, 2 stores and 1 error → stat_loads=3, stat_stores=2, stat_errs=1.
